// File: rtl/fixed_point_pkg.sv
// rtl/fixed_point_pkg.sv - shared fixed-point widths, range helpers and divider state type
package fixed_point_pkg;

    localparam int FIXED_POINT_LENGTH_DEFAULT   = 16;
    localparam int FIXED_POINT_POSITION_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FINISH = 2'd2
    } div_state_e;

    // Largest two's-complement value representable in 'width' bits
    function automatic longint fp_max_value(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Most negative two's-complement value representable in 'width' bits
    function automatic longint fp_min_value(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/fixed_point_saturator.sv
// rtl/fixed_point_saturator.sv - narrows a wide signed value to OUT_WIDTH bits, clamping or wrapping
module fixed_point_saturator
    import fixed_point_pkg::*;
#(
    parameter int IN_WIDTH  = 27,
    parameter int OUT_WIDTH = 16,
    parameter bit SATURATE  = 1'b1
) (
    input  logic signed [IN_WIDTH-1:0]  value_in,
    output logic        [OUT_WIDTH-1:0] value_out,
    output logic                        overflow_out
);

    localparam logic signed [IN_WIDTH-1:0] MAX_W = IN_WIDTH'(fp_max_value(OUT_WIDTH));
    localparam logic signed [IN_WIDTH-1:0] MIN_W = IN_WIDTH'(fp_min_value(OUT_WIDTH));

    logic above;
    logic below;

    // Range test on the full-width value; the overflow flag is reported whether or not we clamp
    always_comb begin
        above        = value_in > MAX_W;
        below        = value_in < MIN_W;
        overflow_out = above | below;
        value_out    = value_in[OUT_WIDTH-1:0];
        if (SATURATE && above) begin
            value_out = MAX_W[OUT_WIDTH-1:0];
        end else if (SATURATE && below) begin
            value_out = MIN_W[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/signed_fixed_point_divider.sv
// rtl/signed_fixed_point_divider.sv - restoring signed fixed-point divider; SIGNED_FIXED_POINT_DIVIDER_SATURATION_EN clamps overflow
module signed_fixed_point_divider
    import fixed_point_pkg::*;
#(
    parameter int FIXED_POINT_LENGTH   = FIXED_POINT_LENGTH_DEFAULT,
    parameter int FIXED_POINT_POSITION = FIXED_POINT_POSITION_DEFAULT
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          start_in,
    input  logic [FIXED_POINT_LENGTH-1:0] dividend_in,
    input  logic [FIXED_POINT_LENGTH-1:0] divisor_in,
    output logic                          busy_out,
    output logic                          done_out,
    output logic [FIXED_POINT_LENGTH-1:0] quotient_out,
    output logic                          overflow_out,
    output logic                          div_by_zero_out
);

    localparam int N  = FIXED_POINT_LENGTH;
    localparam int F  = FIXED_POINT_POSITION;
    localparam int W  = N + F;
    localparam int RW = N + 1;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] COUNT_INIT = CW'(W - 1);
    localparam logic [N-1:0]  Q_MAX      = N'(fp_max_value(N));
    localparam logic [N-1:0]  Q_MIN      = N'(fp_min_value(N));
`ifdef SIGNED_FIXED_POINT_DIVIDER_SATURATION_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    div_state_e state;
    div_state_e state_next;

    logic [N-1:0]        divisor_mag;
    logic [W-1:0]        numerator;
    logic [W-1:0]        quotient_mag;
    logic [N:0]          remainder;
    logic [CW-1:0]       count;
    logic                result_neg;
    logic                dividend_neg;
    logic                zero_divisor;

    logic [N-1:0]        dividend_abs;
    logic [N-1:0]        divisor_abs;
    logic [N+1:0]        rem_shift;
    logic                rem_ge;
    logic signed [W:0]   result_wide;
    logic [N-1:0]        sat_value;
    logic                sat_overflow;

    // Operand magnitudes; the most negative value maps to 2^(N-1), which still fits unsigned
    always_comb begin
        dividend_abs = dividend_in[N-1] ? (~dividend_in) + N'(1) : dividend_in;
        divisor_abs  = divisor_in[N-1]  ? (~divisor_in)  + N'(1) : divisor_in;
    end

    // One restoring step: bring in the next numerator bit and trial-subtract the divisor
    always_comb begin
        rem_shift   = {remainder, numerator[W-1]};
        rem_ge      = rem_shift >= {2'b00, divisor_mag};
        result_wide = result_neg ? -$signed({1'b0, quotient_mag}) : $signed({1'b0, quotient_mag});
    end

    fixed_point_saturator #(
        .IN_WIDTH  (W + 1),
        .OUT_WIDTH (N),
        .SATURATE  (SATURATE)
    ) u_saturator (
        .value_in     (result_wide),
        .value_out    (sat_value),
        .overflow_out (sat_overflow)
    );

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept in IDLE, fixed N+F iterations in DIVIDE, single FINISH cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_in) state_next = DIVIDE;
            DIVIDE:  if (count == '0) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered result outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            divisor_mag     <= '0;
            numerator       <= '0;
            quotient_mag    <= '0;
            remainder       <= '0;
            count           <= '0;
            result_neg      <= 1'b0;
            dividend_neg    <= 1'b0;
            zero_divisor    <= 1'b0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            quotient_out    <= '0;
            overflow_out    <= 1'b0;
            div_by_zero_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        divisor_mag  <= divisor_abs;
                        numerator    <= {dividend_abs, {F{1'b0}}};
                        quotient_mag <= '0;
                        remainder    <= '0;
                        count        <= COUNT_INIT;
                        result_neg   <= dividend_in[N-1] ^ divisor_in[N-1];
                        dividend_neg <= dividend_in[N-1];
                        zero_divisor <= (divisor_in == '0);
                        busy_out     <= 1'b1;
                    end
                end
                DIVIDE: begin
                    numerator    <= {numerator[W-2:0], 1'b0};
                    remainder    <= rem_ge ? RW'(rem_shift - {2'b00, divisor_mag}) : rem_shift[N:0];
                    quotient_mag <= {quotient_mag[W-2:0], rem_ge};
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end
                end
                FINISH: begin
                    busy_out <= 1'b0;
                    done_out <= 1'b1;
                    if (zero_divisor) begin
                        // Divide by zero keeps the fixed latency and reports a signed full-scale value
                        quotient_out    <= dividend_neg ? Q_MIN : Q_MAX;
                        overflow_out    <= 1'b0;
                        div_by_zero_out <= 1'b1;
                    end else begin
                        quotient_out    <= sat_value;
                        overflow_out    <= sat_overflow;
                        div_by_zero_out <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
